// File: rtl/clk_int_div_meas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_int_div_meas_pkg
// Description : Shared definitions for the integer clock-divider measurement
//               block: FSM state encoding and default parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_int_div_meas_pkg;

    localparam int DEF_CNT_WIDTH   = 32;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT_CYC = 65535;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_HIGH = 3'd2,
        ST_LOW  = 3'd3,
        ST_DONE = 3'd4
    } meas_state_t;

endpackage
`default_nettype wire

// File: rtl/clk_int_div_meas_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_int_div_meas_if
// Description : Request / result handshake bundle of the divider measurement
//               block.
//               master : requester side (drives start/abort/res_ready)
//               slave  : measurement block side (drives ready/result/status)
//               start_valid_i/start_ready_o : measurement request handshake
//               abort_i                     : cancel measurement in progress
//               res_valid_o/res_ready_i     : result handshake
//               high_cnt_o/low_cnt_o/div_o  : measured counts and divider code
//               timeout_o                   : result invalid (timeout/saturate)
//               busy_o                      : block not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_int_div_meas_if
    import clk_int_div_meas_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) ();

    logic                 start_valid_i;
    logic                 start_ready_o;
    logic                 abort_i;
    logic                 res_valid_o;
    logic                 res_ready_i;
    logic [CNT_WIDTH-1:0] high_cnt_o;
    logic [CNT_WIDTH-1:0] low_cnt_o;
    logic [CNT_WIDTH-1:0] div_o;
    logic                 timeout_o;
    logic                 busy_o;

    modport master (
        output start_valid_i, abort_i, res_ready_i,
        input  start_ready_o, res_valid_o, high_cnt_o, low_cnt_o,
               div_o, timeout_o, busy_o
    );

    modport slave (
        input  start_valid_i, abort_i, res_ready_i,
        output start_ready_o, res_valid_o, high_cnt_o, low_cnt_o,
               div_o, timeout_o, busy_o
    );

endinterface
`default_nettype wire

// File: rtl/clk_int_div_meas_sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : clk_sync_edge_det
// Description : Synchronizes the measured clock into the clk_i domain and
//               flags its rising/falling edges one cycle wide.
//               clk_i, rst_n_i : clock, synchronous active-low reset
//               meas_clk_i     : asynchronous level to be sampled
//               rise_o/fall_o  : single-cycle edge strobes
//               level_o        : synchronized level
//               SYNC_STAGES legal range is 2..4.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_sync_edge_det
    import clk_int_div_meas_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  wire  clk_i,
    input  wire  rst_n_i,
    input  wire  meas_clk_i,
    output logic rise_o,
    output logic fall_o,
    output logic level_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], meas_clk_i};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    // Edges compare the last synchronizer stage with one extra delayed copy,
    // so both strobes carry the same latency and period measurements cancel it.
    assign level_o = r_sync[SYNC_STAGES-1];
    assign rise_o  =  r_sync[SYNC_STAGES-1] & ~r_dly;
    assign fall_o  = ~r_sync[SYNC_STAGES-1] &  r_dly;

endmodule
`default_nettype wire

// File: rtl/clk_int_div_meas.sv
`default_nettype none
// ============================================================================
// Module      : clk_int_div_meas
// Description : Measures high/low time (in clk_i cycles) of one period of a
//               divided clock and reports the equivalent divider code.
//               clk_i      : system clock (rising edge)
//               rst_n_i    : synchronous active-low reset
//               meas_clk_i : clock under measurement, sampled as data
//               bus        : request/result handshake (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_int_div_meas
    import clk_int_div_meas_pkg::*;
#(
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  wire                clk_i,
    input  wire                rst_n_i,
    input  wire                meas_clk_i,
    clk_int_div_meas_if.slave  bus
);

    localparam int                   c_TMO_WIDTH = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TMO_WIDTH-1:0] c_TMO_LIMIT = c_TMO_WIDTH'(TIMEOUT_CYC);

    logic w_rise;
    logic w_fall;
    logic w_level_unused;

    meas_state_t            r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_high,  w_high_nxt;
    logic [CNT_WIDTH-1:0]   r_low,   w_low_nxt;
    logic [c_TMO_WIDTH-1:0] r_tmo,   w_tmo_nxt;
    logic                   r_timeout, w_timeout_nxt;

    logic [CNT_WIDTH-1:0]   w_high_inc;
    logic [CNT_WIDTH-1:0]   w_low_inc;
    logic [c_TMO_WIDTH-1:0] w_tmo_inc;
    logic                   w_tmo_hit;
    logic [CNT_WIDTH:0]     w_div_full;

    clk_sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .meas_clk_i (meas_clk_i),
        .rise_o     (w_rise),
        .fall_o     (w_fall),
        .level_o    (w_level_unused)
    );

    assign w_high_inc = r_high + CNT_WIDTH'(1);
    assign w_low_inc  = r_low  + CNT_WIDTH'(1);
    assign w_tmo_inc  = r_tmo  + c_TMO_WIDTH'(1);
    assign w_tmo_hit  = (w_tmo_inc == c_TMO_LIMIT);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_high    <= '0;
            r_low     <= '0;
            r_tmo     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_high    <= w_high_nxt;
            r_low     <= w_low_nxt;
            r_tmo     <= w_tmo_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Abort is tested first in every active state so it beats edges,
    // timeouts and the result handshake.
    always_comb begin
        w_state_nxt   = r_state;
        w_high_nxt    = r_high;
        w_low_nxt     = r_low;
        w_tmo_nxt     = r_tmo;
        w_timeout_nxt = r_timeout;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_valid_i) begin
                    w_state_nxt   = ST_ARM;
                    w_high_nxt    = '0;
                    w_low_nxt     = '0;
                    w_tmo_nxt     = '0;
                    w_timeout_nxt = 1'b0;
                end
            end
            ST_ARM: begin
                if (bus.abort_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                    w_high_nxt  = CNT_WIDTH'(1);
                    w_tmo_nxt   = '0;
                end else begin
                    w_tmo_nxt = w_tmo_inc;
                    if (w_tmo_hit) begin
                        w_state_nxt   = ST_DONE;
                        w_timeout_nxt = 1'b1;
                    end
                end
            end
            ST_HIGH: begin
                if (bus.abort_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_fall) begin
                    w_state_nxt = ST_LOW;
                    w_low_nxt   = CNT_WIDTH'(1);
                    w_tmo_nxt   = '0;
                end else begin
                    w_high_nxt = w_high_inc;
                    w_tmo_nxt  = w_tmo_inc;
                    if (w_tmo_hit || (w_high_inc == '1)) begin
                        w_state_nxt   = ST_DONE;
                        w_timeout_nxt = 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (bus.abort_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rise) begin
                    // The closing rise ends the period; it is not a low cycle.
                    w_state_nxt = ST_DONE;
                    w_tmo_nxt   = '0;
                end else begin
                    w_low_nxt = w_low_inc;
                    w_tmo_nxt = w_tmo_inc;
                    if (w_tmo_hit || (w_low_inc == '1)) begin
                        w_state_nxt   = ST_DONE;
                        w_timeout_nxt = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.abort_i || bus.res_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // One extra bit catches both overflow and the high=low=0 underflow; either
    // case reports all-ones.
    assign w_div_full = {1'b0, r_high} + {1'b0, r_low} - {{CNT_WIDTH{1'b0}}, 1'b1};

    assign bus.start_ready_o = (r_state == ST_IDLE);
    assign bus.busy_o        = (r_state != ST_IDLE);
    assign bus.res_valid_o   = (r_state == ST_DONE);
    assign bus.high_cnt_o    = r_high;
    assign bus.low_cnt_o     = r_low;
    assign bus.timeout_o     = r_timeout;
    assign bus.div_o         = w_div_full[CNT_WIDTH] ? '1 : w_div_full[CNT_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_clk_int_div_meas.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_int_div_meas
// Description : Self-checking bench for clk_int_div_meas. Results are
//               predicted from the waveform's high/low lengths and compared
//               whenever res_valid_o is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_int_div_meas;

    localparam int W   = 4;
    localparam int S   = 2;
    localparam int TMO = 16;
    localparam int MAXV = (1 << W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic meas  = 1'b0;
    int   rdy_mode = 0;   // 0 random, 1 hold low, 2 hold high

    clk_int_div_meas_if #(.CNT_WIDTH(W)) bus ();

    clk_int_div_meas #(
        .CNT_WIDTH   (W),
        .SYNC_STAGES (S),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .meas_clk_i (meas),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int l;
        int d;
        bit chk_div;
        bit t;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_done = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected result of measuring a waveform with h cycles high, l low.
    function automatic exp_t model(input int h, input int l);
        exp_t e;
        e.chk_div = 1'b1;
        e.t       = 1'b0;
        e.h       = h;
        e.l       = l;
        if (h >= MAXV) begin
            e.h = MAXV; e.l = 0; e.t = 1'b1;
        end else if (l >= MAXV) begin
            e.l = MAXV; e.t = 1'b1;
        end
        e.d = e.h + e.l - 1;
        if (e.d > MAXV) e.d = MAXV;
        return e;
    endfunction

    function automatic exp_t lit(input int h, input int l, input int d, input bit t);
        exp_t e;
        e.h = h; e.l = l; e.d = d; e.t = t; e.chk_div = 1'b1;
        return e;
    endfunction

    // Consumer ready, changed well away from the active edge.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            1:       bus.res_ready_i = 1'b0;
            2:       bus.res_ready_i = 1'b1;
            default: bus.res_ready_i = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Compare process: every cycle out of reset.
    initial begin : checker_proc
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                check("busy_vs_ready", int'(bus.busy_o), int'(!bus.start_ready_o));
                if (bus.res_valid_o) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_valid: got res_valid=1, expected 0 (t=%0t)", $time);
                    end else begin
                        e = exp_q[0];
                        check("high_cnt", int'(bus.high_cnt_o), e.h);
                        check("low_cnt",  int'(bus.low_cnt_o),  e.l);
                        check("timeout",  int'(bus.timeout_o),  int'(e.t));
                        if (e.chk_div) check("div", int'(bus.div_o), e.d);
                        if (bus.res_ready_i && !bus.abort_i) begin
                            void'(exp_q.pop_front());
                            n_done++;
                        end
                    end
                end
            end
        end
    end

    task automatic start_meas();
        int budget;
        budget = 60;
        while (!bus.start_ready_o && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("ready_before_start", int'(bus.start_ready_o), 1);
        bus.start_valid_i = 1'b1;
        @(negedge clk);
        bus.start_valid_i = 1'b0;
        check("busy_after_start", int'(bus.busy_o), 1);
    endtask

    task automatic drive_wave(input int h, input int l, input int periods);
        for (int p = 0; p < periods; p++) begin
            meas = 1'b1;
            repeat (h) @(negedge clk);
            meas = 1'b0;
            repeat (l) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = 300;
        while (bus.busy_o && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(name, int'(bus.busy_o), 0);
    endtask

    task automatic settle_low();
        meas = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_meas(input exp_t e, input int h, input int l);
        int d0;
        settle_low();
        d0 = n_done;
        start_meas();
        exp_q.push_back(e);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        drive_wave(h, l, 3);
        wait_idle("meas_complete");
        check("result_consumed", n_done - d0, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int cnt;
        int h;
        int l;
        bus.start_valid_i = 1'b0;
        bus.abort_i       = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy",      int'(bus.busy_o),      0);
        check("rst_res_valid", int'(bus.res_valid_o), 0);
        check("rst_timeout",   int'(bus.timeout_o),   0);
        check("rst_high",      int'(bus.high_cnt_o),  0);
        check("rst_low",       int'(bus.low_cnt_o),   0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", int'(bus.start_ready_o), 1);

        // Directed waveforms with hand-computed results
        run_meas(lit(3, 5, 7, 1'b0), 3, 5);
        run_meas(lit(2, 2, 3, 1'b0), 2, 2);      // divide-by-4 source
        run_meas(lit(1, 1, 1, 1'b0), 1, 1);      // divide-by-2 source
        run_meas(lit(9, 9, MAXV, 1'b0), 9, 9);   // divider code saturates
        run_meas(lit(MAXV, 0, MAXV - 1, 1'b1), 16, 3);  // high count saturates
        run_meas(lit(4, MAXV, MAXV, 1'b1), 4, 20);      // low count saturates

        // No edges: timeout exactly TMO cycles after entering ARM
        settle_low();
        start_meas();
        exp_q.push_back('{h: 0, l: 0, d: 0, chk_div: 1'b0, t: 1'b1});
        cnt = 0;
        while (!bus.res_valid_o && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("arm_timeout_cycles", cnt, TMO);
        wait_idle("timeout_complete");

        // Result held while consumer stalls; start requests ignored
        rdy_mode = 1;
        settle_low();
        start_meas();
        exp_q.push_back(lit(3, 5, 7, 1'b0));
        drive_wave(3, 5, 3);
        cnt = 0;
        while (!bus.res_valid_o && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("hold_valid_seen", int'(bus.res_valid_o), 1);
        for (int i = 0; i < 10; i++) begin
            bus.start_valid_i = (i % 2 == 0);
            @(negedge clk);
            check("hold_valid",       int'(bus.res_valid_o),   1);
            check("hold_start_ready", int'(bus.start_ready_o), 0);
        end
        bus.start_valid_i = 1'b0;
        rdy_mode = 2;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_ack_valid", int'(bus.res_valid_o),   0);
        check("idle_after_ack_ready", int'(bus.start_ready_o), 1);
        rdy_mode = 0;

        // Abort in HIGH on the same cycle the fall is acted on
        settle_low();
        start_meas();
        meas = 1'b1;
        repeat (6) @(negedge clk);
        meas = 1'b0;
        repeat (S) @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        check("abort_busy",      int'(bus.busy_o),        0);
        check("abort_ready",     int'(bus.start_ready_o), 1);
        check("abort_res_valid", int'(bus.res_valid_o),   0);
        repeat (TMO + 8) @(negedge clk);
        check("abort_stays_idle", int'(bus.busy_o), 0);

        // One-cycle reset while in LOW
        settle_low();
        start_meas();
        meas = 1'b1;
        repeat (4) @(negedge clk);
        meas = 1'b0;
        repeat (S + 3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_busy",      int'(bus.busy_o),        0);
        check("mid_rst_ready",     int'(bus.start_ready_o), 1);
        check("mid_rst_res_valid", int'(bus.res_valid_o),   0);
        check("mid_rst_high",      int'(bus.high_cnt_o),    0);
        check("mid_rst_low",       int'(bus.low_cnt_o),     0);
        check("mid_rst_timeout",   int'(bus.timeout_o),     0);
        repeat (TMO + 8) @(negedge clk);
        check("mid_rst_stays_idle", int'(bus.busy_o), 0);
        run_meas(lit(3, 5, 7, 1'b0), 3, 5);

        // Randomized waveforms checked against the model
        for (int k = 0; k < 16; k++) begin
            h = $urandom_range(1, 16);
            l = $urandom_range(1, 16);
            run_meas(model(h, l), h, l);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_int_div_meas.md
CLK_INT_DIV_MEAS -- requirements
Module: clk_int_div_meas

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 32, setting the width of every count/result field.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, setting the meas_clk_i synchronizer depth (legal range 2..4).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 2^16-1, setting the max clk_i cycles allowed between consecutive detected edges.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is clocked on the rising edge.
REQ-005 The block SHALL have port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port meas_clk_i, input, 1 bit: the divided clock under measurement, sampled as data.
REQ-007 The block SHALL have port start_valid_i, input, 1 bit: measurement request.
REQ-008 The block SHALL have port start_ready_o, output, 1 bit: the block accepts a request.
REQ-009 The block SHALL have port abort_i, input, 1 bit: cancels a measurement in progress.
REQ-010 The block SHALL have port res_valid_o, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port res_ready_i, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have ports high_cnt_o and low_cnt_o, outputs, CNT_WIDTH bits each: clk_i cycles spent high and low.
REQ-013 The block SHALL have port div_o, output, CNT_WIDTH bits: high+low-1, i.e. the divider encoding (divide ratio = div_o+1).
REQ-014 The block SHALL have port timeout_o, output, 1 bit: the result is invalid because an edge failed to arrive or a count saturated.
REQ-015 The block SHALL have port busy_o, output, 1 bit: asserted whenever the state is not IDLE.

Function
REQ-016 meas_clk_i SHALL pass through a SYNC_STAGES flop chain; an edge is detected from the last stage versus one extra delayed flop.
REQ-017 The FSM SHALL have states IDLE, ARM, HIGH, LOW and DONE.
REQ-018 IDLE: start_ready_o=1; start_valid_i&start_ready_o SHALL go to ARM and clear the counts and the timeout counter.
REQ-019 ARM SHALL wait for a detected rise, then go to HIGH with high count=1.
REQ-020 HIGH SHALL increment the high count each cycle; a detected fall SHALL go to LOW with low count=1.
REQ-021 LOW SHALL increment the low count each cycle; the next detected rise SHALL go to DONE without incrementing the low count.
REQ-022 Consequence of REQ-019..021: a waveform high H and low L cycles SHALL report high_cnt_o=H, low_cnt_o=L, div_o=H+L-1; synchronizer latency cancels.
REQ-023 DONE: res_valid_o=1 and all results SHALL be held stable until res_valid_o&res_ready_i, which returns to IDLE.
REQ-024 start_ready_o SHALL be 0 outside IDLE; start_valid_i SHALL be ignored in those states.
REQ-025 The timeout counter SHALL clear on every detected edge in ARM/HIGH/LOW; reaching TIMEOUT_CYC SHALL go to DONE with timeout_o=1 and partial counts.
REQ-026 A high or low count reaching all-ones SHALL saturate and force DONE with timeout_o=1.
REQ-027 abort_i in ARM/HIGH/LOW/DONE SHALL return to IDLE next cycle with res_valid_o=0; abort_i has priority over any simultaneous edge, timeout or handshake.
REQ-028 div_o SHALL be computed with CNT_WIDTH+1-bit sum then saturated to all-ones if it overflows.
REQ-029 start_valid_i and res_ready_i SHALL be accepted in the same cycle as the state change, with no extra bubble.

Reset
REQ-030 While rst_n_i=0 at a clk_i edge: state=IDLE, counts=0, timeout_o=0, res_valid_o=0, busy_o=0, synchronizer flops=0.
REQ-031 start_ready_o SHALL be 1 from the first cycle after reset deassertion.
REQ-032 Reset asserted mid-measurement SHALL discard the measurement, with no partial result ever presented.

Structure
REQ-033 Package clk_int_div_meas_pkg SHALL hold the FSM state enum and the default CNT_WIDTH/TIMEOUT_CYC constants.
REQ-034 The synchronizer and rise/fall detection SHALL be one sub-module, clk_sync_edge_det (params SYNC_STAGES; outputs rise_o, fall_o, level_o).
REQ-035 All flops SHALL use the synchronous-reset register variant; there is no asynchronous reset path.

Verification
REQ-036 Drive meas_clk_i high 3 / low 5 repeatedly, then start -> high=3, low=5, div_o=7, timeout_o=0.
REQ-037 Drive from clk_int_div_simple with div_i=3 -> high=2, low=2, div_o=3; with div_i=1 -> high=1, low=1, div_o=1.
REQ-038 Hold meas_clk_i=0, TIMEOUT_CYC=16, start -> DONE with timeout_o=1 exactly 16 cycles after ARM entry, counts=0.
REQ-039 Hold res_ready_i=0 for 10 cycles in DONE -> res_valid_o and results stable; start_valid_i pulses ignored; then ready -> IDLE next cycle.
REQ-040 Assert abort_i in HIGH coincident with a fall edge -> IDLE next cycle, res_valid_o never 1.
REQ-041 Assert rst_n_i=0 for one cycle in LOW -> all outputs at reset values next cycle; a following start measures correctly.
